// File: rtl/dmem_bus_pkg.sv
// Shared constants for the data-memory / MMIO responder: MMIO decode tag,
// MMIO register word offsets and CON_STAT bit positions.
package dmem_bus_pkg;

  localparam logic [3:0] MMIO_TAG_DEF = 4'hF;

  // MMIO register word offsets (i_addr[3:0])
  localparam logic [3:0] REG_CYCLE_LO = 4'd0;
  localparam logic [3:0] REG_CYCLE_HI = 4'd1;
  localparam logic [3:0] REG_LEDS     = 4'd2;
  localparam logic [3:0] REG_CON_DATA = 4'd3;
  localparam logic [3:0] REG_CON_STAT = 4'd4;

  // CON_STAT layout
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle (the freed head slot takes the new entry).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head is forced to zero while empty so the port reads 0 after reset
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage: not reset, only ever read behind a valid pointer
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_bus.sv
// Responder end of the CPU load/store bus: byte-maskable RAM plus a small
// MMIO block (cycle counter with atomic HI shadow, LEDs, console FIFO).
// Load data is registered and appears one cycle after the address.
module dmem_bus
  import dmem_bus_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter logic [3:0] MMIO_TAG  = MMIO_TAG_DEF,
  parameter int         CON_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_is_store,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [3:0]  i_store_mask,
  output logic [31:0] o_load_data,
  output logic [7:0]  o_leds,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready
);
  localparam int CW = $clog2(CON_DEPTH) + 1;

  logic [3:0][7:0]   ram [2**ADDR_W];
  logic              is_mmio;
  logic [ADDR_W-1:0] ram_idx;
  logic [3:0]        off;
  logic [31:0]       ram_rd, mmio_rd;
  logic [63:0]       cycle_cnt;
  logic [31:0]       cycle_hi_shadow;
  logic              con_ovf, con_full, con_empty, con_push, con_pop;
  logic [CW-1:0]     con_count;
  logic              mmio_st, mmio_ld;
  logic              unused;

  assign is_mmio = (i_addr[29:26] == MMIO_TAG);
  assign ram_idx = i_addr[ADDR_W-1:0];
  assign off     = i_addr[3:0];
  assign mmio_st = i_is_store && is_mmio;
  assign mmio_ld = !i_is_store && is_mmio;
  assign ram_rd  = ram[ram_idx];
  assign unused  = ^i_addr;

  assign con_push    = mmio_st && (off == REG_CON_DATA) && i_store_mask[0];
  assign con_pop     = o_con_valid && i_con_ready;
  assign o_con_valid = !con_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(CON_DEPTH)) u_con_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (con_push),
    .pop   (con_pop),
    .din   (i_store_data[7:0]),
    .dout  (o_con_data),
    .full  (con_full),
    .empty (con_empty),
    .count (con_count)
  );

  // RAM byte-lane writes; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (i_is_store && !is_mmio) begin
      for (int k = 0; k < 4; k++)
        if (i_store_mask[k]) ram[ram_idx][k] <= i_store_data[8*k +: 8];
    end
  end

  // MMIO read mux; unmapped offsets read zero
  always_comb begin
    mmio_rd = '0;
    case (off)
      REG_CYCLE_LO: mmio_rd = cycle_cnt[31:0];
      REG_CYCLE_HI: mmio_rd = cycle_hi_shadow;
      REG_LEDS:     mmio_rd = {24'd0, o_leds};
      REG_CON_STAT: begin
        mmio_rd[STAT_FULL]                 = con_full;
        mmio_rd[STAT_EMPTY]                = con_empty;
        mmio_rd[STAT_OVF]                  = con_ovf;
        mmio_rd[STAT_CNT_LSB +: 8]         = 8'(con_count);
      end
      default:      mmio_rd = '0;
    endcase
  end

  // MMIO state: free-running counter, HI shadow, LEDs, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt       <= '0;
      cycle_hi_shadow <= '0;
      o_leds          <= '0;
      con_ovf         <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      // capturing HI on the LO read makes a LO-then-HI pair atomic
      if (mmio_ld && off == REG_CYCLE_LO) cycle_hi_shadow <= cycle_cnt[63:32];
      if (mmio_st && off == REG_LEDS && i_store_mask[0]) o_leds <= i_store_data[7:0];
      if (con_push && con_full && !con_pop)
        con_ovf <= 1'b1;
      else if (mmio_st && off == REG_CON_STAT && i_store_mask[0] && i_store_data[STAT_OVF])
        con_ovf <= 1'b0;
    end
  end

  // registered load data; value after a store cycle is don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_load_data <= '0;
    else        o_load_data <= is_mmio ? mmio_rd : ram_rd;
  end

endmodule

// File: tb/tb_dmem_bus.sv
// Directed bench for dmem_bus with scoreboard queues: the driver pushes the
// expected load word / console byte, separate monitors pop and compare.
module tb_dmem_bus;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_is_store;
  logic [29:0] i_addr;
  logic [31:0] i_store_data;
  logic [3:0]  i_store_mask;
  logic [31:0] o_load_data;
  logic [7:0]  o_leds;
  logic        o_con_valid;
  logic [7:0]  o_con_data;
  logic        i_con_ready;

  logic        ld_req;
  logic [31:0] ld_q[$];
  string       nm_q[$];
  logic [7:0]  con_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  localparam logic [29:0] MM = 30'h3C00_0000;

  dmem_bus dut (
    .clk(clk), .rst_n(rst_n), .i_is_store(i_is_store), .i_addr(i_addr),
    .i_store_data(i_store_data), .i_store_mask(i_store_mask),
    .o_load_data(o_load_data), .o_leds(o_leds), .o_con_valid(o_con_valid),
    .o_con_data(o_con_data), .i_con_ready(i_con_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    i_is_store = 1'b0; i_addr = '0; i_store_mask = '0; ld_req = 1'b0;
  endtask

  task automatic st(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    i_is_store = 1'b1; i_addr = a; i_store_data = d; i_store_mask = m; ld_req = 1'b0;
  endtask

  task automatic ld(input logic [29:0] a, input logic [31:0] e, input string nm);
    @(negedge clk);
    i_is_store = 1'b0; i_addr = a; i_store_mask = '0; ld_req = 1'b1;
    ld_q.push_back(e); nm_q.push_back(nm);
  endtask

  // load monitor: a load presented before this edge is due just after it
  initial begin
    forever begin
      @(posedge clk);
      if (ld_req && rst_n) begin
        #1;
        if (ld_q.size() == 0) begin
          n_chk++;
          $display("FAIL load_sb: load seen with empty scoreboard");
        end else chk(nm_q.pop_front(), o_load_data, ld_q.pop_front());
      end
    end
  end

  // console monitor: compare the head byte on every handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && o_con_valid && i_con_ready) begin
        if (con_q.size() == 0) begin
          n_chk++;
          $display("FAIL con_sb: unexpected byte 0x%02h", o_con_data);
        end else chk("con_byte", {24'd0, o_con_data}, {24'd0, con_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0; i_is_store = 1'b0; i_addr = '0; i_store_data = '0;
    i_store_mask = '0; i_con_ready = 1'b0; ld_req = 1'b0;
    #2;
    chk("rst_load", o_load_data, 32'd0);
    chk("rst_leds", {24'd0, o_leds}, 32'd0);
    chk("rst_valid", {31'd0, o_con_valid}, 32'd0);
    chk("rst_con_data", {24'd0, o_con_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // counter reads 20 after 20 edges out of reset
    repeat (20) @(posedge clk);
    ld(MM | 30'd0, 32'd20, "cycle_lo_20");

    // LO read while counter sits at 0xFFFFFFFF; HI must come from the shadow
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    i_is_store = 1'b0; i_addr = MM | 30'd0; ld_req = 1'b1;
    ld_q.push_back(32'hFFFF_FFFF); nm_q.push_back("cycle_lo_wrap");
    @(posedge clk); #2;
    release dut.cycle_cnt;
    idle();
    ld(MM | 30'd1, 32'd0, "cycle_hi_shadow");

    // RAM byte masks
    st(30'h10, 32'hDEAD_BEEF, 4'b1111);
    st(30'h10, 32'h0000_00AA, 4'b0001);
    st(30'h10, 32'h5500_0000, 4'b1000);
    ld(30'h10, 32'h55AD_BEAA, "ram_mask");
    // store then immediate load, plus aliased address
    st(30'h3FF, 32'h1234_5678, 4'b1111);
    ld(30'h3FF, 32'h1234_5678, "ram_raw");
    ld(30'h7FF, 32'h1234_5678, "ram_alias");
    st(30'h3FF, 32'hFFFF_FFFF, 4'b0000);
    ld(30'h3FF, 32'h1234_5678, "ram_mask0");

    // LEDs
    st(MM | 30'd2, 32'h0000_00C3, 4'b0001);
    @(posedge clk); #1;
    chk("leds_write", {24'd0, o_leds}, 32'hC3);
    st(MM | 30'd2, 32'h0000_00FF, 4'b0010);
    @(posedge clk); #1;
    chk("leds_mask", {24'd0, o_leds}, 32'hC3);
    ld(MM | 30'd2, 32'h0000_00C3, "leds_read");
    ld(MM | 30'd7, 32'd0, "mmio_unmapped");

    // console: 9 pushes into an 8-deep FIFO with the sink stalled
    for (int i = 0; i < 9; i++) begin
      st(MM | 30'd3, 32'h41 + i, 4'b0001);
      if (i < 8) con_q.push_back(8'(8'h41 + i));
    end
    ld(MM | 30'd3, 32'd0, "con_data_read");
    ld(MM | 30'd4, 32'h0000_0805, "stat_full_ovf");
    st(MM | 30'd4, 32'h0000_0004, 4'b0001);
    ld(MM | 30'd4, 32'h0000_0801, "stat_ovf_clr");

    // push while full with a simultaneous pop
    @(negedge clk);
    i_con_ready = 1'b1;
    i_is_store = 1'b1; i_addr = MM | 30'd3; i_store_data = 32'h5A;
    i_store_mask = 4'b0001; ld_req = 1'b0;
    con_q.push_back(8'h5A);
    ld(MM | 30'd4, 32'h0000_0801, "stat_pushpop");

    // drain, bounded
    for (int i = 0; i < 30 && o_con_valid; i++) idle();
    idle();
    chk("con_drained", {31'd0, o_con_valid}, 32'd0);
    chk("con_sb_empty", con_q.size(), 32'd0);
    ld(MM | 30'd4, 32'h0000_0002, "stat_empty");

    // asynchronous reset mid-stream
    i_con_ready = 1'b0;
    st(MM | 30'd3, 32'h77, 4'b0001);
    ld(30'h10, 32'h55AD_BEAA, "ram_before_rst");
    @(posedge clk); #3;
    rst_n = 1'b0; ld_req = 1'b0;
    #1;
    chk("arst_load", o_load_data, 32'd0);
    chk("arst_leds", {24'd0, o_leds}, 32'd0);
    chk("arst_valid", {31'd0, o_con_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle();
    idle();
    chk("load_sb_empty", ld_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
